// File: rtl/shift_ram_ctrl.sv
// shift_ram_ctrl: valid/ready flow controller for the shift_ram_buffer_counter
// delay line. It primes the buffer with DEPTH words before presenting output.
// On flush it drains the stored words by shifting in zero words. It also tracks
// how many live words the buffer currently holds.
module shift_ram_ctrl #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 256,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             buf_ce,
  output logic [WIDTH-1:0] buf_d,
  input  logic [WIDTH-1:0] buf_q,
  output logic [LW-1:0]    level,
  output logic             flush_done
);

  // gap counts pending alignment pushes, so it never needs to reach DEPTH
  localparam int GW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [LW-1:0]   count_reg, count_next;
  logic [GW-1:0]   gap_reg, gap_next;
  logic            flush_done_reg, flush_done_next;
  logic            ce;

  // State, live-word count, alignment gap and the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      gap_reg        <= '0;
      flush_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      gap_reg        <= gap_next;
      flush_done_reg <= flush_done_next;
    end
  end

  // Next-state logic and handshake/strobe decode for each state
  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    gap_next        = gap_reg;
    flush_done_next = 1'b0;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    ce              = 1'b0;
    buf_d           = in_data;

    case (state_reg)
      IDLE: begin
        in_ready = ~flush;
        ce       = in_valid & ~flush;
        if (flush) begin
          flush_done_next = 1'b1;
        end else if (in_valid) begin
          count_next = LW'(1);
          state_next = FILL;
        end
      end

      FILL: begin
        in_ready = ~flush;
        ce       = in_valid & ~flush;
        if (flush) begin
          // Zero pushes still needed so the oldest live word reaches buf_q
          gap_next   = GW'(FULL - count_reg);
          state_next = DRAIN;
        end else if (in_valid) begin
          count_next = count_reg + 1'b1;
          if (count_reg == FULL - 1'b1) begin
            state_next = RUN;
          end
        end
      end

      RUN: begin
        // Push and pop are the same edge, so count holds at DEPTH
        out_valid = in_valid & ~flush;
        in_ready  = out_ready & ~flush;
        ce        = in_valid & out_ready & ~flush;
        if (flush) begin
          gap_next   = '0;
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        buf_d = '0;
        if (gap_reg != '0) begin
          ce       = 1'b1;
          gap_next = gap_reg - 1'b1;
        end else begin
          // out_valid is independent of out_ready here
          out_valid = 1'b1;
          ce        = out_ready;
          if (out_ready) begin
            count_next = count_reg - 1'b1;
            if (count_reg == LW'(1)) begin
              state_next      = IDLE;
              flush_done_next = 1'b1;
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Hold the buffer still while reset is asserted, whatever in_valid does
  assign buf_ce     = ce & rst_n;
  assign out_data   = buf_q;
  assign level      = count_reg;
  assign flush_done = flush_done_reg;

endmodule

// File: tb/tb_shift_ram_ctrl.sv
// tb_shift_ram_ctrl: directed bench for shift_ram_ctrl with DEPTH=4. A
// behavioural delay line stands in for the buffer. Expected output words are
// queued by the stimulus, and a monitor pops and compares them on every transfer.
module tb_shift_ram_ctrl;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             buf_ce;
  logic [WIDTH-1:0] buf_d;
  logic [WIDTH-1:0] buf_q;
  logic [LW-1:0]    level;
  logic             flush_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];

  shift_ram_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .buf_ce     (buf_ce),
    .buf_d      (buf_d),
    .buf_q      (buf_q),
    .level      (level),
    .flush_done (flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural delay line: no reset, starts with garbage
  logic [WIDTH-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 64'hDEAD_0000_0000_0000 + 64'(i);
  always @(posedge clk) begin
    if (buf_ce) begin
      for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i - 1];
      mem[0] <= buf_d;
    end
  end
  assign buf_q = mem[DEPTH - 1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Scoreboard monitor: one line per output transfer
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_data: got %0d, expected no transfer (t=%0t)", out_data, $time);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL out_data: got %0d, expected %0d (t=%0t)", out_data, e, $time);
        end else begin
          $display("xfer out_data=%0d ok (t=%0t)", out_data, $time);
        end
      end
    end
  end

  // Push n words, flush with in_valid high, then drain (optionally toggling out_ready)
  task automatic fill_flush(input int base, input int n, input bit toggle);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(base + i);
      adv();
      chk("fill_level", 64'(level), 64'(i + 1));
    end
    in_data = 64'(base + n);
    flush   = 1'b1;
    neg();
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    chk("flush_buf_ce", 64'(buf_ce), 64'd0);
    adv();
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int g = 0; g < DEPTH - n; g++) begin
      neg();
      chk("gap_out_valid", 64'(out_valid), 64'd0);
      chk("gap_buf_ce", 64'(buf_ce), 64'd1);
      chk("gap_buf_d", buf_d, 64'd0);
      adv();
    end
    for (int i = 0; i < n; i++) exp_q.push_back(64'(base + i));
    for (int k = 0; k < (toggle ? 2 * n : n); k++) begin
      if (toggle) out_ready = (k % 2 == 1);
      neg();
      chk("drain_out_valid", 64'(out_valid), 64'd1);
      chk("drain_buf_ce", 64'(buf_ce), 64'(out_ready));
      adv();
    end
    chk("drain_flush_done", 64'(flush_done), 64'd1);
    chk("drain_level", 64'(level), 64'd0);
    out_ready = 1'b1;
    adv();
    chk("drain_flush_done_clr", 64'(flush_done), 64'd0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) adv();
    rst_n = 1'b1;

    // 1. Asynchronous reset in the middle of a fill
    in_valid = 1'b1;
    in_data  = 64'd1;
    adv();
    in_data = 64'd2;
    adv();
    in_data = 64'd3;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_buf_ce", 64'(buf_ce), 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    adv();
    rst_n = 1'b1;
    adv();

    // 2. Prime with 100..103, then stream
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(100 + i);
      neg();
      chk("prime_out_valid", 64'(out_valid), 64'd0);
      chk("prime_buf_ce", 64'(buf_ce), 64'd1);
      adv();
      chk("prime_level", 64'(level), 64'(i + 1));
    end
    chk("prime_state_run", 64'(dut.state_reg), 64'd2);
    in_data = 64'd104;
    exp_q.push_back(64'd100);
    neg();
    chk("run_out_valid", 64'(out_valid), 64'd1);
    adv();
    in_data = 64'd105;
    exp_q.push_back(64'd101);
    adv();
    chk("run_level", 64'(level), 64'd4);

    // 3. Backpressure for five cycles with 106 offered
    in_data   = 64'd106;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_buf_ce", 64'(buf_ce), 64'd0);
      chk("bp_level", 64'(level), 64'd4);
      chk("bp_buf_q", buf_q, 64'd102);
      adv();
    end
    out_ready = 1'b1;
    exp_q.push_back(64'd102);
    neg();
    chk("bp_release_buf_ce", 64'(buf_ce), 64'd1);
    adv();
    in_data = 64'd107;
    exp_q.push_back(64'd103);
    adv();
    in_valid = 1'b0;

    // 4. Flush in RUN: no gap, 104..107 drain on consecutive cycles
    flush = 1'b1;
    neg();
    chk("runflush_out_valid", 64'(out_valid), 64'd0);
    chk("runflush_buf_ce", 64'(buf_ce), 64'd0);
    chk("runflush_in_ready", 64'(in_ready), 64'd0);
    adv();
    flush = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(64'(104 + i));
    for (int i = 0; i < DEPTH; i++) begin
      neg();
      chk("rdrain_out_valid", 64'(out_valid), 64'd1);
      chk("rdrain_buf_ce", 64'(buf_ce), 64'd1);
      chk("rdrain_buf_d", buf_d, 64'd0);
      adv();
      chk("rdrain_level", 64'(level), 64'(3 - i));
      if (i < DEPTH - 1) chk("rdrain_flush_done_early", 64'(flush_done), 64'd0);
    end
    chk("rdrain_flush_done", 64'(flush_done), 64'd1);
    chk("rdrain_in_ready", 64'(in_ready), 64'd1);
    adv();
    chk("rdrain_flush_done_clr", 64'(flush_done), 64'd0);

    // Flush in IDLE: no buffer activity, done on the next cycle
    flush = 1'b1;
    neg();
    chk("idleflush_buf_ce", 64'(buf_ce), 64'd0);
    adv();
    flush = 1'b0;
    chk("idleflush_done", 64'(flush_done), 64'd1);
    chk("idleflush_level", 64'(level), 64'd0);
    adv();
    chk("idleflush_done_clr", 64'(flush_done), 64'd0);

    // 5. Flush in FILL, plain and with toggling out_ready, plus gap=1 boundary
    fill_flush(200, 2, 1'b0);
    fill_flush(210, 2, 1'b1);
    fill_flush(220, 3, 1'b0);

    // 6. Reset while draining, then refill
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(240 + i);
      adv();
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    adv();
    flush = 1'b0;
    exp_q.push_back(64'd240);
    adv();
    rst_n = 1'b0;
    #1;
    chk("middrain_rst_level", 64'(level), 64'd0);
    chk("middrain_rst_out_valid", 64'(out_valid), 64'd0);
    adv();
    rst_n = 1'b1;
    chk("middrain_no_done", 64'(flush_done), 64'd0);
    adv();
    chk("middrain_no_done2", 64'(flush_done), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(300 + i);
      neg();
      chk("refill_out_valid", 64'(out_valid), 64'd0);
      adv();
    end
    in_data = 64'd304;
    exp_q.push_back(64'd300);
    neg();
    chk("refill_first_out", 64'(out_valid), 64'd1);
    adv();
    in_valid = 1'b0;
    neg();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_ram_ctrl.md
# shift_ram_ctrl

Flow controller for the `shift_ram_buffer_counter` delay line. It converts upstream and downstream valid/ready streams into the buffer's single `ce` strobe, and tracks how many live words the buffer holds. It primes the buffer with DEPTH words before it presents output. On `flush` it drains the stored words by shifting in zero words. It sits between a producer stream and `shift_ram_buffer_counter` in the line-buffer datapath.

## Interface
- WIDTH, 64, data word width; must equal the buffer's WIDTH
- DEPTH, 256, buffer depth; must equal the buffer's DEPTH; DEPTH ≥ 2
- LW, derived = clog2(DEPTH+1), width of `level`

- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  upstream may transfer
- in_data  in  WIDTH  upstream word
- flush  in  1  single-cycle request to drain all stored words
- out_valid  out  1  `out_data` holds the oldest live word
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  combinational pass-through of `buf_q`
- buf_ce  out  1  drives buffer `ce`
- buf_d  out  WIDTH  drives buffer `d`
- buf_q  in  WIDTH  from buffer `q`
- level  out  LW  live-word count, 0..DEPTH
- flush_done  out  1  one-cycle pulse when a drain completes

## Operation
- **Buffer contract.** Each `clk` edge with `buf_ce=1` shifts `buf_d` in. After push n (n ≥ DEPTH), `buf_q` holds the word from push n−DEPTH+1. The buffer has no reset, so its contents after reset are garbage.
- **Registers.** `state` ∈ {IDLE, FILL, RUN, DRAIN}, `count` (= `level`), and `gap` (0..DEPTH−1, the number of pending alignment pushes).
- **IDLE** (count=0).
  - `in_ready=~flush`, `out_valid=0`, `buf_ce=in_valid&~flush`, `buf_d=in_data`.
  - Push: count←1, go to FILL.
  - `flush`: pulse `flush_done` on the next cycle and stay in IDLE.
- **FILL** (0<count<DEPTH).
  - `in_ready=~flush`, `out_valid=0`, `buf_ce=in_valid&~flush`, `buf_d=in_data`.
  - Each push increments count. When count reaches DEPTH, go to RUN.
  - `flush`: no push that cycle; gap←DEPTH−count; go to DRAIN.
- **RUN** (count=DEPTH).
  - `out_valid=in_valid&~flush`, `in_ready=out_ready&~flush`, `buf_ce=in_valid&out_ready&~flush`, `buf_d=in_data`.
  - A push always pops, and a pop always pushes, so count stays at DEPTH.
  - `flush`: no transfer that cycle; gap←0; go to DRAIN.
- **DRAIN.**
  - `in_ready=0` and `buf_d=0` throughout.
  - While gap>0: `buf_ce=1`, `out_valid=0`, gap decrements each cycle.
  - Once gap=0: `out_valid=1`, `buf_ce=out_ready`. Each transfer decrements count.
  - On the transfer that takes count to 0: go to IDLE and pulse `flush_done` on the next cycle.
  - `flush` is ignored while in DRAIN.
- **Flush priority.** `flush` overrides `in_valid` in the same cycle; the upstream word is not accepted.
- **Path rule.** `out_valid` depends combinationally on `in_valid` only in RUN. There is no combinational path from `out_ready` to `out_valid`.

## Timing
- **Reset values.** While `rst_n` is low, and asynchronously on its falling edge:
  - state=IDLE, count=0, gap=0, `flush_done=0`, `out_valid=0`, `buf_ce=0`.
  - `in_ready=1` once `flush` is low.
- **Reset mid-operation.** Stored words are abandoned. After release the controller refills from count=0 and does not trust stale `buf_q`.
- **Latency.** The first `out_valid` appears in the same cycle that the (DEPTH+1)-th word is offered in RUN.
- **Drain length.** A drain takes gap+count cycles under full `out_ready`. `flush_done` asserts in the cycle after the last transfer.
- **Handshakes.**
  - A transfer occurs on an edge where valid&ready=1.
  - `buf_ce` is high exactly on upstream transfers (IDLE, FILL, RUN), alignment pushes, and drain pops.
- **Flush at a fill boundary.**
  - Flush at count=DEPTH−1: gap=1.
  - Flush in IDLE: no buffer activity, `flush_done` on the next cycle.

## Test plan
DEPTH=4, WIDTH=64 for all scenarios.
1. **Reset.** Assert `rst_n=0` mid-clock → `level=0`, `out_valid=0`, `buf_ce=0`, `flush_done=0`, `in_ready=1`, asynchronously before the next edge.
2. **Prime and stream.** Push 100..103 with `out_ready=1` → `out_valid=0` throughout, `level` 1,2,3,4, state RUN. Then offer 104 → `out_valid=1`, `out_data=100`; 105 → `out_data=101`; `level` stays 4.
3. **Backpressure.** In RUN, hold `out_ready=0` with `in_valid=1` for 5 cycles → `in_ready=0`, `buf_ce=0`, `level=4`, `buf_q` unchanged. Release → the stream resumes with no loss or duplication.
4. **Flush in RUN.** After 100..105 are pushed and 100,101 popped, pulse `flush` → no gap cycles; outputs 102,103,104,105 on four consecutive cycles with `buf_ce=1` and `buf_d=0`; `level` 3,2,1,0; `flush_done` on the next cycle; state IDLE.
5. **Flush in FILL.** Push 200,201 → `level=2`; pulse `flush` with `in_valid=1` → 202 is not accepted; 2 cycles of `buf_ce=1` with `out_valid=0`; then `out_data` 200, 201; then `flush_done`. Repeat with `out_ready` toggling every cycle → same order, pops only on ready.
6. **Reset mid-drain.** Assert `rst_n` low at the second drain output → IDLE, `level=0`, no `flush_done`. Refill 300..303, then offer 304 → first output 300.
